// File: rtl/seg_spin_monitor_if.sv
// Segment bus and monitor result signals for seg_spin_monitor.
// master: side driving seg_n and observing results; slave: the monitor itself.
interface seg_spin_monitor_if;
  logic [7:0] seg_n;
  logic       valid;
  logic [7:0] pattern;
  logic [3:0] digit;
  logic       is_digit;
  logic [2:0] spin_step;
  logic       spin_lock;
  logic       spin_err;
  logic [7:0] rev_count;

  modport master (
    output seg_n,
    input  valid, pattern, digit, is_digit, spin_step, spin_lock, spin_err, rev_count
  );

  modport slave (
    input  seg_n,
    output valid, pattern, digit, is_digit, spin_step, spin_lock, spin_err, rev_count
  );
endinterface

// File: rtl/seg_spin_monitor.sv
// Glitch-filtered receiver for an active-low 7-segment bus with spinner sequence tracking.
// Define SEG_MON_HEX_EN to compile in the hex glyph decoder (digit/is_digit); otherwise both read 0.
//
// state     | meaning
// ST_IDLE   | waiting for spinner step 0 (0x01); spin_step holds
// ST_TRACK  | following the spinner, fewer than LOCK_STEPS good transitions
// ST_LOCKED | LOCK_STEPS good transitions seen; 7->0 wraps count revolutions
module seg_spin_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned LOCK_STEPS    = 8
) (
  input  logic              clk,
  input  logic              reset,
  seg_spin_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } spin_state_t;

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYCLES);
  localparam logic [7:0] LOCK_W   = 8'(LOCK_STEPS);

  function automatic logic [6:0] spin_code(input logic [2:0] idx);
    logic [6:0] code;
    case (idx)
      3'd0:    code = 7'h01;
      3'd1:    code = 7'h02;
      3'd2:    code = 7'h40;
      3'd3:    code = 7'h10;
      3'd4:    code = 7'h08;
      3'd5:    code = 7'h04;
      3'd6:    code = 7'h40;
      default: code = 7'h20;
    endcase
    return code;
  endfunction

  // ---------------- stability filter ----------------
  logic [7:0] sample;
  logic [7:0] prev_sample;
  logic [7:0] stable_cnt;
  logic [7:0] last_acc;
  logic       run_done;
  logic       accept;

  assign sample = ~bus.seg_n;

  // run_done makes acceptance one-shot per run even when the counter saturates
  assign accept = (stable_cnt >= STABLE_W) && !run_done && (prev_sample != last_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_sample <= 8'h00;
      stable_cnt  <= 8'h00;
      run_done    <= 1'b0;
      last_acc    <= 8'h00;
    end else begin
      prev_sample <= sample;
      if (sample != prev_sample) begin
        stable_cnt <= 8'd1;
        run_done   <= 1'b0;
      end else begin
        if (stable_cnt != 8'hFF) stable_cnt <= stable_cnt + 8'd1;
        if (stable_cnt >= STABLE_W) run_done <= 1'b1;
      end
      if (accept) last_acc <= prev_sample;
    end
  end

  // ---------------- spinner tracker ----------------
  spin_state_t state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  run_q, run_d;
  logic [7:0]  rev_q, rev_d;
  logic        err_q, err_d;
  logic [6:0]  acc_seg;
  logic [6:0]  exp_next;
  logic [7:0]  run_inc;

  assign acc_seg  = prev_sample[6:0];
  assign exp_next = spin_code(step_q + 3'd1);
  assign run_inc  = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      step_q  <= 3'd0;
      run_q   <= 8'd0;
      rev_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      run_q   <= run_d;
      rev_q   <= rev_d;
      err_q   <= err_d;
    end
  end

  // step 2 and step 6 share the g code, so matching is always against the expected next step
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    run_d   = run_q;
    rev_d   = rev_q;
    err_d   = 1'b0;
    if (accept) begin
      if (acc_seg == 7'h00) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        if (acc_seg == 7'h01) begin
          state_d = ST_TRACK;
          step_d  = 3'd0;
          run_d   = 8'd0;
        end
      end else if (acc_seg == exp_next) begin
        step_d = step_q + 3'd1;
        run_d  = run_inc;
        if (run_inc >= LOCK_W) state_d = ST_LOCKED;
        if ((state_q == ST_LOCKED) && (step_q == 3'd7)) rev_d = rev_q + 8'd1;
      end else begin
        err_d = 1'b1;
        if (acc_seg == 7'h01) begin
          state_d = ST_TRACK;
          step_d  = 3'd0;
          run_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // ---------------- outputs ----------------
  logic       valid_q;
  logic [7:0] pattern_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pattern_q <= 8'h00;
    end else begin
      valid_q <= accept;
      if (accept) pattern_q <= prev_sample;
    end
  end

  assign bus.valid     = valid_q;
  assign bus.pattern   = pattern_q;
  assign bus.spin_step = step_q;
  assign bus.spin_lock = (state_q == ST_LOCKED);
  assign bus.spin_err  = err_q;
  assign bus.rev_count = rev_q;

`ifdef SEG_MON_HEX_EN
  function automatic logic [4:0] hex_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h3F:   r = 5'h10;
      7'h06:   r = 5'h11;
      7'h5B:   r = 5'h12;
      7'h4F:   r = 5'h13;
      7'h66:   r = 5'h14;
      7'h6D:   r = 5'h15;
      7'h7D:   r = 5'h16;
      7'h07:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h6F:   r = 5'h19;
      7'h77:   r = 5'h1A;
      7'h7C:   r = 5'h1B;
      7'h39:   r = 5'h1C;
      7'h5E:   r = 5'h1D;
      7'h79:   r = 5'h1E;
      7'h71:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [3:0] digit_q;
  logic       is_digit_q;
  logic [4:0] dec;

  assign dec = hex_decode(prev_sample[6:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q    <= 4'd0;
      is_digit_q <= 1'b0;
    end else if (accept) begin
      digit_q    <= dec[3:0];
      is_digit_q <= dec[4];
    end
  end

  assign bus.digit    = digit_q;
  assign bus.is_digit = is_digit_q;
`else
  assign bus.digit    = 4'd0;
  assign bus.is_digit = 1'b0;
`endif

endmodule

// File: tb/tb_seg_spin_monitor.sv
// Self-checking bench for seg_spin_monitor: directed scenarios plus randomized traffic
// compared against a sample-history reference model.
module tb_seg_spin_monitor;
  localparam int S = 4;
  localparam int L = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  seg_spin_monitor_if bus();

  seg_spin_monitor #(.STABLE_CYCLES(S), .LOCK_STEPS(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0] spin_seq [8]  = '{8'h01, 8'h02, 8'h40, 8'h10, 8'h08, 8'h04, 8'h40, 8'h20};
  logic [7:0] glyph    [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // reference model state
  logic [7:0] hist [$];
  int         tot        = 0;
  logic [7:0] m_last     = 8'h00;
  logic       m_valid    = 1'b0;
  logic [7:0] m_pattern  = 8'h00;
  logic [3:0] m_digit    = 4'd0;
  logic       m_is_digit = 1'b0;
  logic       m_err      = 1'b0;
  int         m_step = 0, m_mode = 0, m_run = 0, m_rev = 0;

  task automatic model_edge();
    logic [7:0] v;
    logic [7:0] p;
    logic       acc;
    int         n;
    if (reset) begin
      hist.delete();
      tot = 0; m_last = 8'h00; m_valid = 1'b0; m_pattern = 8'h00;
      m_digit = 4'd0; m_is_digit = 1'b0; m_err = 1'b0;
      m_step = 0; m_mode = 0; m_run = 0; m_rev = 0;
      return;
    end
    acc = 1'b0;
    v   = 8'h00;
    n   = hist.size();
    // accept when the last S samples form the start of a run and differ from the last accepted value
    if (tot >= S) begin
      v   = hist[n-1];
      acc = 1'b1;
      for (int i = n - S; i < n; i++) if (hist[i] != v) acc = 1'b0;
      if (tot > S && hist[n-S-1] == v) acc = 1'b0;
      if (v == m_last) acc = 1'b0;
    end
    hist.push_back(~bus.seg_n);
    tot++;
    if (hist.size() > 64) void'(hist.pop_front());
    m_valid = acc;
    m_err   = 1'b0;
    if (acc) begin
      m_last    = v;
      m_pattern = v;
      m_digit    = 4'd0;
      m_is_digit = 1'b0;
`ifdef SEG_MON_HEX_EN
      for (int d = 0; d < 16; d++)
        if (glyph[d][6:0] == v[6:0]) begin m_digit = 4'(d); m_is_digit = 1'b1; end
`endif
      p = v & 8'h7F;
      if (p == 8'h00) m_mode = 0;
      else if (m_mode == 0) begin
        if (p == 8'h01) begin m_mode = 1; m_step = 0; m_run = 0; end
      end else if (p == spin_seq[(m_step + 1) % 8]) begin
        if (m_mode == 2 && m_step == 7) m_rev = (m_rev + 1) % 256;
        m_step = (m_step + 1) % 8;
        if (m_run < 255) m_run++;
        if (m_run >= L) m_mode = 2;
      end else begin
        m_err = 1'b1;
        if (p == 8'h01) begin m_mode = 1; m_step = 0; m_run = 0; end
        else m_mode = 0;
      end
    end
  endtask

  task automatic cycle(input logic [7:0] sn, input logic rst);
    @(negedge clk);
    bus.seg_n = sn;
    reset     = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(~p, 1'b0);
  endtask

  function automatic logic [27:0] all_outs();
    return {bus.valid, bus.pattern, bus.digit, bus.is_digit, bus.spin_step,
            bus.spin_lock, bus.spin_err, bus.rev_count};
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(8'hFF, 1'b1);
      vectors++;
      if (all_outs() !== 28'd0) begin
        errors++; $display("FAIL reset_outs: got %h want 0", all_outs());
      end
    end
    for (int i = 0; i < 50; i++) begin
      cycle(8'hFF, 1'b0);
      vectors++;
      if (all_outs() !== 28'd0) begin
        errors++; $display("FAIL blank_hold cyc %0d: got %h want 0", i, all_outs());
      end
    end
  endtask

  task automatic test_digit();
    for (int i = 0; i < 10; i++) begin
      cycle(~8'h06, 1'b0);
      vectors++;
      if (bus.valid !== (i == 4)) begin
        errors++; $display("FAIL digit_valid cyc %0d: got %b want %b", i, bus.valid, (i == 4));
      end
      if (i == 4) begin
        vectors++;
        if (bus.pattern !== 8'h06) begin
          errors++; $display("FAIL digit_pattern: got %h want 06", bus.pattern);
        end
        vectors++;
`ifdef SEG_MON_HEX_EN
        if ({bus.is_digit, bus.digit} !== 5'h11) begin
          errors++; $display("FAIL digit_decode: got %b/%h want 1/1", bus.is_digit, bus.digit);
        end
`else
        if ({bus.is_digit, bus.digit} !== 5'h00) begin
          errors++; $display("FAIL digit_decode: got %b/%h want 0/0", bus.is_digit, bus.digit);
        end
`endif
      end
    end
    for (int i = 0; i < 13; i++) begin
      cycle((i < 3) ? ~8'h7F : ~8'h06, 1'b0);
      vectors++;
      if (bus.valid !== 1'b0 || bus.pattern !== 8'h06) begin
        errors++; $display("FAIL glitch cyc %0d: got valid=%b pattern=%h want 0/06", i, bus.valid, bus.pattern);
      end
    end
  endtask

  task automatic test_spin_lock();
    int k = 0;
    int want_rev;
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 8; s++) begin
        if (r == 3 && s > 0) break;
        for (int c = 0; c < 5; c++) begin
          cycle(~spin_seq[s], 1'b0);
          vectors++;
          if (bus.spin_err !== 1'b0) begin
            errors++; $display("FAIL spin_err_quiet k=%0d: got %b want 0", k, bus.spin_err);
          end
          if (bus.valid) begin
            k++;
            want_rev = (k >= 25) ? 2 : (k >= 17) ? 1 : 0;
            vectors++;
            if (bus.spin_lock !== (k >= 9) || bus.rev_count !== 8'(want_rev) ||
                bus.spin_step !== 3'(s)) begin
              errors++;
              $display("FAIL spin_track k=%0d: got lock=%b rev=%0d step=%0d want %b/%0d/%0d",
                       k, bus.spin_lock, bus.rev_count, bus.spin_step, (k >= 9), want_rev, s);
            end
          end
        end
      end
    end
    vectors++;
    if (k !== 25) begin
      errors++; $display("FAIL spin_accepts: got %0d want 25", k);
    end
  endtask

  task automatic test_break();
    int errs = 0;
    hold(8'h02, 5);
    hold(8'h40, 5);
    vectors++;
    if (bus.spin_lock !== 1'b1 || bus.spin_step !== 3'd2) begin
      errors++; $display("FAIL break_pre: got lock=%b step=%0d want 1/2", bus.spin_lock, bus.spin_step);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(~8'h04, 1'b0);
      if (bus.spin_err) errs++;
      if (bus.valid) begin
        vectors++;
        if (bus.spin_err !== 1'b1 || bus.spin_lock !== 1'b0) begin
          errors++; $display("FAIL break_err: got err=%b lock=%b want 1/0", bus.spin_err, bus.spin_lock);
        end
      end
    end
    vectors++;
    if (errs !== 1) begin
      errors++; $display("FAIL break_err_width: got %0d cycles want 1", errs);
    end
    hold(8'h01, 6);
    vectors++;
    if (bus.spin_step !== 3'd0 || bus.spin_lock !== 1'b0 || bus.spin_err !== 1'b0) begin
      errors++; $display("FAIL restart: got step=%0d lock=%b err=%b want 0/0/0", bus.spin_step, bus.spin_lock, bus.spin_err);
    end
    hold(8'h02, 5);
    vectors++;
    if (bus.spin_step !== 3'd1 || bus.spin_err !== 1'b0) begin
      errors++; $display("FAIL track_after_restart: got step=%0d err=%b want 1/0", bus.spin_step, bus.spin_err);
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 2; s < 8; s++) hold(spin_seq[s], 5);
    for (int s = 0; s < 8; s++) hold(spin_seq[s], 5);
    for (int s = 0; s < 6; s++) hold(spin_seq[s], 5);
    vectors++;
    if (bus.spin_step !== 3'd5 || bus.rev_count !== 8'd3 || bus.spin_lock !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got step=%0d rev=%0d lock=%b want 5/3/1", bus.spin_step, bus.rev_count, bus.spin_lock);
    end
    cycle(~8'h01, 1'b1);
    vectors++;
    if (all_outs() !== 28'd0) begin
      errors++; $display("FAIL mid_reset: got %h want 0", all_outs());
    end
    for (int i = 0; i < 6; i++) begin
      cycle(~8'h01, 1'b0);
      vectors++;
      if (bus.valid !== (i == 4)) begin
        errors++; $display("FAIL reaccept_valid cyc %0d: got %b want %b", i, bus.valid, (i == 4));
      end
    end
    vectors++;
    if (bus.pattern !== 8'h01 || bus.spin_step !== 3'd0 || bus.spin_lock !== 1'b0) begin
      errors++; $display("FAIL reaccept: got pattern=%h step=%0d lock=%b want 01/0/0", bus.pattern, bus.spin_step, bus.spin_lock);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic [7:0] prev_v = 8'h01;
    int cyc = 0;
    int n;
    while (cyc < 1500) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: v = (m_mode == 0) ? 8'h01 : spin_seq[(m_step + 1) % 8];
        5:             v = 8'h01;
        6:             v = 8'h00;
        7:             v = glyph[$urandom_range(0, 15)];
        8:             v = 8'($urandom_range(0, 255));
        default:       v = prev_v;
      endcase
      if ($urandom_range(0, 7) == 0) v[7] = 1'b1;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        cycle(~v, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        cyc++;
        vectors++;
        if ({bus.valid, bus.pattern} !== {m_valid, m_pattern}) begin
          errors++; $display("FAIL rnd_filter cyc %0d: got %b/%h want %b/%h", cyc, bus.valid, bus.pattern, m_valid, m_pattern);
        end
        vectors++;
        if ({bus.is_digit, bus.digit} !== {m_is_digit, m_digit}) begin
          errors++; $display("FAIL rnd_decode cyc %0d: got %b/%h want %b/%h", cyc, bus.is_digit, bus.digit, m_is_digit, m_digit);
        end
        vectors++;
        if ({bus.spin_step, bus.spin_lock, bus.spin_err, bus.rev_count} !==
            {3'(m_step), (m_mode == 2), m_err, 8'(m_rev)}) begin
          errors++;
          $display("FAIL rnd_spin cyc %0d: got step=%0d lock=%b err=%b rev=%0d want %0d/%b/%b/%0d",
                   cyc, bus.spin_step, bus.spin_lock, bus.spin_err, bus.rev_count,
                   m_step, (m_mode == 2), m_err, m_rev);
        end
      end
      prev_v = v;
    end
  endtask

  initial begin
    bus.seg_n = 8'hFF;
    test_reset();
    test_digit();
    test_spin_lock();
    test_break();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
